ederah_dispatch: RTL and testbench
==================================

Name: ederah_dispatch

Overview:
- Single-clock job front-end for a multi-engine EDERAH array; successor to the single-engine kernel controller.
- Owns ap_* job control and the NFA-reload decision, and splits one input stream into NFA (broadcast) and query (round-robin) traffic across G_NUM_ENGINES engine wrappers.
- Merges engine results back into one ordered output stream.
- Sits between the input/result CDC FIFOs and the engine wrappers, all in kernel clock domain.

Parameters:
G_DATA_BUS_WIDTH, 512, tdata width of every stream.
G_NUM_ENGINES, 4, number of engines (1..16).
G_HASH_WIDTH, 64, NFA hash width.
G_CNT_WIDTH, 32, query/result beat counter width.

Ports:
clk_i  in  1  kernel clock.
rst_i  in  1  reset, asynchronous, active-high.
ap_start_i  in  1  job start level; rising edge starts a job.
ap_idle_o  out  1  no job active.
ap_done_o  out  1  job finished; sticky until next start.
ap_ready_o  out  1  equals ap_done_o.
nfa_hash_i  in  G_HASH_WIDTH  hash of NFA for this job; sampled on start edge.
s_data_i  in  G_DATA_BUS_WIDTH  input beat.
s_valid_i  in  1  input valid.
s_last_i  in  1  end of NFA section or end of query section.
s_ready_o  out  1  input ready.
eng_data_o  out  G_NUM_ENGINES*G_DATA_BUS_WIDTH  per-engine beat (all lanes carry s_data_i).
eng_valid_o  out  G_NUM_ENGINES  per-engine valid.
eng_last_o  out  G_NUM_ENGINES  per-engine last.
eng_stype_o  out  G_NUM_ENGINES  0 = NFA beat, 1 = query beat.
eng_ready_i  in  G_NUM_ENGINES  per-engine ready.
res_data_i  in  G_NUM_ENGINES*G_DATA_BUS_WIDTH  per-engine result beat.
res_valid_i  in  G_NUM_ENGINES  per-engine result valid.
res_ready_o  out  G_NUM_ENGINES  per-engine result ready.
m_data_o  out  G_DATA_BUS_WIDTH  merged result.
m_valid_o  out  1  merged valid.
m_last_o  out  1  last result beat of job.
m_ready_i  in  1  merged ready.

Behaviour:
- Reset: all outputs 0 except ap_idle_o=1. State IDLE, hash_valid=0, counters 0, rr pointers 0, taken bits 0.
- Start edge = ap_start_i & ~ap_start_q. Accepted only in IDLE; ignored otherwise.
- Start edge clears ap_done_o, drops ap_idle_o and latches nfa_hash_i into hash_pend.
- Reload: when hash_valid=0 or nfa_hash_i != hash_q, IDLE->READ_NFA; else IDLE->READ_QUERY.
- READ_NFA (broadcast):
  - eng_valid_o[i] = s_valid_i & ~taken[i]; stype 0.
  - taken[i] sets on eng_valid&eng_ready.
  - s_ready_o = 1 in the cycle where every lane is taken or handshaking; taken then clears.
  - On accepted s_last_i: hash_q <= hash_pend, hash_valid <= 1, go to READ_QUERY.
- READ_QUERY (round-robin):
  - Only lane in_ptr gets valid; s_ready_o = eng_ready_i[in_ptr]; stype 1.
  - Each accepted beat increments in_ptr (wraps at G_NUM_ENGINES-1 to 0) and q_cnt.
  - Accepted s_last_i latches total=q_cnt+1, sets in_done and goes to DRAIN.
- DRAIN: s_ready_o=0 and all eng_valid_o=0.
- s_ready_o=0 in IDLE.
- Zero combinational latency s->eng; eng_last_o mirrors s_last_i on the active lane(s).
- Engine contract: exactly one result beat per query beat, in input order per engine.
- Merge:
  - m_valid_o = res_valid_i[out_ptr]; m_data_o = lane out_ptr; res_ready_o[out_ptr] = m_ready_i; other lanes 0.
  - Each handshake increments out_ptr (wrap) and r_cnt.
- m_last_o = in_done & (r_cnt+1 == total).
- Merged handshake with m_last_o: ap_done_o <= 1, ap_idle_o <= 1, state IDLE, counters and pointers cleared.
- Merge is active in READ_QUERY and DRAIN. Results may overlap input.
- Counters wrap modulo 2^G_CNT_WIDTH. Jobs above 2^G_CNT_WIDTH-1 beats are unsupported.
- Reset mid-job: hash_valid clears, so the next job always reloads.
- Start edge in the same cycle as the done handshake: ignored, because the state is not yet IDLE.

Optional Feature:
EDERAH_DISPATCH_PERF_EN:
- Defined: adds outputs perf_cycles_o[31:0] and perf_stall_o[31:0].
  - perf_cycles_o counts cycles from start edge to done.
  - perf_stall_o counts cycles with s_valid_i=1 and s_ready_o=0 outside IDLE.
  - Both clear on start edge and hold after done.
- Not defined: ports absent, no counters.

Test Plan:
- N=4, hash 0xA5 after reset, 3 NFA beats + 8 query beats, all ready -> NFA on all 4 lanes with stype 0; queries to lanes 0,1,2,3,0,1,2,3; 8 results in order; m_last_o on 8th; ap_done_o=1, ap_idle_o=1.
- Second job with same hash 0xA5 -> no NFA phase; first input beat goes to lane 0 with stype 1.
- NFA broadcast where lane 2 asserts ready 3 cycles late -> s_ready_o low until lane 2 takes the beat; no lane sees the beat twice.
- 5 query beats with lane 1 results delayed 10 cycles, m_ready_i toggling -> output order 0,1,2,3,0; m_last_o only on 5th beat.
- rst_i pulse during READ_QUERY, then job with same hash -> outputs return to reset values; next job reloads NFA.
- ap_start_i held high across two jobs, and a start edge while busy -> exactly one job per rising edge; busy-time edge ignored.

Source files
------------

// File: rtl/ederah_dispatch.sv
// ederah_dispatch: job control, NFA broadcast / query round-robin split, result merge.
// Optional perf counters when EDERAH_DISPATCH_PERF_EN is defined.
module ederah_dispatch #(
  parameter int G_DATA_BUS_WIDTH = 512,
  parameter int G_NUM_ENGINES    = 4,
  parameter int G_HASH_WIDTH     = 64,
  parameter int G_CNT_WIDTH      = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    ap_start_i,
  output logic                                    ap_idle_o,
  output logic                                    ap_done_o,
  output logic                                    ap_ready_o,
  input  logic [G_HASH_WIDTH-1:0]                 nfa_hash_i,
  input  logic [G_DATA_BUS_WIDTH-1:0]             s_data_i,
  input  logic                                    s_valid_i,
  input  logic                                    s_last_i,
  output logic                                    s_ready_o,
  output logic [G_NUM_ENGINES*G_DATA_BUS_WIDTH-1:0] eng_data_o,
  output logic [G_NUM_ENGINES-1:0]                eng_valid_o,
  output logic [G_NUM_ENGINES-1:0]                eng_last_o,
  output logic [G_NUM_ENGINES-1:0]                eng_stype_o,
  input  logic [G_NUM_ENGINES-1:0]                eng_ready_i,
  input  logic [G_NUM_ENGINES*G_DATA_BUS_WIDTH-1:0] res_data_i,
  input  logic [G_NUM_ENGINES-1:0]                res_valid_i,
  output logic [G_NUM_ENGINES-1:0]                res_ready_o,
  output logic [G_DATA_BUS_WIDTH-1:0]             m_data_o,
  output logic                                    m_valid_o,
  output logic                                    m_last_o,
`ifdef EDERAH_DISPATCH_PERF_EN
  output logic [31:0]                             perf_cycles_o,
  output logic [31:0]                             perf_stall_o,
`endif
  input  logic                                    m_ready_i
);

  localparam int DW = G_DATA_BUS_WIDTH;
  localparam int N  = G_NUM_ENGINES;
  localparam int CW = G_CNT_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ_NFA,
    READ_QUERY,
    DRAIN
  } state_t;

  state_t                  state;
  logic                    ap_start_q;
  logic                    start_edge;
  logic                    hash_valid;
  logic [G_HASH_WIDTH-1:0] hash_q;
  logic [G_HASH_WIDTH-1:0] hash_pend;
  logic [N-1:0]            taken;
  logic [PW-1:0]           in_ptr;
  logic [PW-1:0]           out_ptr;
  logic [CW-1:0]           q_cnt;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           total;
  logic                    in_done;
  logic                    merge_act;
  logic                    s_acc;
  logic                    m_acc;
  logic [N-1:0]            eng_hs;

  assign start_edge = ap_start_i & ~ap_start_q;
  assign merge_act  = (state == READ_QUERY) || (state == DRAIN);
  assign s_acc      = s_valid_i & s_ready_o;
  assign m_acc      = m_valid_o & m_ready_i;
  assign eng_hs     = eng_valid_o & eng_ready_i;
  assign eng_data_o = {N{s_data_i}};
  assign ap_ready_o = ap_done_o;

  // Input split: broadcast holds the beat until every lane has taken it.
  always_comb begin
    eng_valid_o = '0;
    eng_last_o  = '0;
    eng_stype_o = '0;
    s_ready_o   = 1'b0;
    unique case (state)
      READ_NFA: begin
        eng_valid_o = {N{s_valid_i}} & ~taken;
        eng_last_o  = {N{s_last_i}} & ~taken;
        s_ready_o   = s_valid_i & (&(taken | eng_ready_i));
      end
      READ_QUERY: begin
        eng_stype_o = '1;
        for (int i = 0; i < N; i++) begin
          if (in_ptr == PW'(i)) begin
            eng_valid_o[i] = s_valid_i;
            eng_last_o[i]  = s_last_i;
            s_ready_o      = eng_ready_i[i];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    m_valid_o   = 1'b0;
    m_data_o    = '0;
    res_ready_o = '0;
    for (int i = 0; i < N; i++) begin
      if (merge_act && out_ptr == PW'(i)) begin
        m_valid_o      = res_valid_i[i];
        m_data_o       = res_data_i[i*DW +: DW];
        res_ready_o[i] = m_ready_i;
      end
    end
  end

  assign m_last_o = merge_act & in_done & ((r_cnt + CW'(1)) == total);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ap_start_q <= 1'b0;
      ap_idle_o  <= 1'b1;
      ap_done_o  <= 1'b0;
      hash_valid <= 1'b0;
      hash_q     <= '0;
      hash_pend  <= '0;
      taken      <= '0;
      in_ptr     <= '0;
      out_ptr    <= '0;
      q_cnt      <= '0;
      r_cnt      <= '0;
      total      <= '0;
      in_done    <= 1'b0;
    end else begin
      ap_start_q <= ap_start_i;
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            ap_done_o <= 1'b0;
            ap_idle_o <= 1'b0;
            hash_pend <= nfa_hash_i;
            state     <= (!hash_valid || nfa_hash_i != hash_q) ?
                         READ_NFA : READ_QUERY;
          end
        end
        READ_NFA: begin
          taken <= taken | eng_hs;
          if (s_acc) begin
            taken <= '0;
            if (s_last_i) begin
              hash_q     <= hash_pend;
              hash_valid <= 1'b1;
              state      <= READ_QUERY;
            end
          end
        end
        READ_QUERY: begin
          if (s_acc) begin
            in_ptr <= (in_ptr == PW'(N-1)) ? '0 : in_ptr + PW'(1);
            q_cnt  <= q_cnt + CW'(1);
            if (s_last_i) begin
              total   <= q_cnt + CW'(1);
              in_done <= 1'b1;
              state   <= DRAIN;
            end
          end
        end
        default: ;
      endcase
      // m_last_o needs in_done, so the job can only close out of DRAIN.
      if (m_acc) begin
        if (m_last_o) begin
          ap_done_o <= 1'b1;
          ap_idle_o <= 1'b1;
          state     <= IDLE;
          in_ptr    <= '0;
          out_ptr   <= '0;
          q_cnt     <= '0;
          r_cnt     <= '0;
          total     <= '0;
          in_done   <= 1'b0;
        end else begin
          out_ptr <= (out_ptr == PW'(N-1)) ? '0 : out_ptr + PW'(1);
          r_cnt   <= r_cnt + CW'(1);
        end
      end
    end
  end

`ifdef EDERAH_DISPATCH_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else if (state == IDLE) begin
      if (start_edge) begin
        perf_cycles_o <= '0;
        perf_stall_o  <= '0;
      end
    end else begin
      perf_cycles_o <= perf_cycles_o + 32'd1;
      if (s_valid_i && !s_ready_o) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ederah_dispatch.sv
// tb_ederah_dispatch: random jobs against a queue-based reference of the
// dispatcher (broadcast / round-robin / ordered merge / hash reuse).
module tb_ederah_dispatch;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int HW = 64;
  localparam int CW = 32;
  localparam int BD = 64;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            rst_i;
  logic            ap_start_i;
  logic            ap_idle_o;
  logic            ap_done_o;
  logic            ap_ready_o;
  logic [HW-1:0]   nfa_hash_i;
  logic [DW-1:0]   s_data_i;
  logic            s_valid_i;
  logic            s_last_i;
  logic            s_ready_o;
  logic [N*DW-1:0] eng_data_o;
  logic [N-1:0]    eng_valid_o;
  logic [N-1:0]    eng_last_o;
  logic [N-1:0]    eng_stype_o;
  logic [N-1:0]    eng_ready_i;
  logic [N*DW-1:0] res_data_i;
  logic [N-1:0]    res_valid_i;
  logic [N-1:0]    res_ready_o;
  logic [DW-1:0]   m_data_o;
  logic            m_valid_o;
  logic            m_last_o;
  logic            m_ready_i;
`ifdef EDERAH_DISPATCH_PERF_EN
  logic [31:0]     perf_cycles_o;
  logic [31:0]     perf_stall_o;
`endif

  ederah_dispatch #(
    .G_DATA_BUS_WIDTH(DW),
    .G_NUM_ENGINES(N),
    .G_HASH_WIDTH(HW),
    .G_CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .ap_start_i(ap_start_i),
    .ap_idle_o(ap_idle_o),
    .ap_done_o(ap_done_o),
    .ap_ready_o(ap_ready_o),
    .nfa_hash_i(nfa_hash_i),
    .s_data_i(s_data_i),
    .s_valid_i(s_valid_i),
    .s_last_i(s_last_i),
    .s_ready_o(s_ready_o),
    .eng_data_o(eng_data_o),
    .eng_valid_o(eng_valid_o),
    .eng_last_o(eng_last_o),
    .eng_stype_o(eng_stype_o),
    .eng_ready_i(eng_ready_i),
    .res_data_i(res_data_i),
    .res_valid_i(res_valid_i),
    .res_ready_o(res_ready_o),
    .m_data_o(m_data_o),
    .m_valid_o(m_valid_o),
    .m_last_o(m_last_o),
`ifdef EDERAH_DISPATCH_PERF_EN
    .perf_cycles_o(perf_cycles_o),
    .perf_stall_o(perf_stall_o),
`endif
    .m_ready_i(m_ready_i)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef enum int {P_IDLE, P_NFA, P_QRY, P_DRAIN} phase_t;
  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  phase_t        phase;
  beat_t         src_q[$];
  logic [DW-1:0] exp_q[$];
  logic [N-1:0]  got;
  logic [N-1:0]  one = 1;
  int            nfa_cnt[N];
  int            n_nfa_exp;
  int            qin, rout, total;
  bit            in_done, done_flag, job_done, hold_v, prev_start;
  bit            hv;
  logic [HW-1:0] hq, hp;
  logic [DW-1:0] ebuf[N][BD];
  int            etm[N][BD];
  int            ehd[N], etl[N];
  int            lat[N];
  int            cyc;
  int            rdy_mode, mr_mode, vprob, late_cnt;
  bit            start_lvl;
  logic [HW-1:0] hash_lvl;

  task automatic model_reset();
    phase = P_IDLE;
    src_q.delete();
    exp_q.delete();
    got = '0;
    qin = 0; rout = 0; total = 0;
    in_done = 0; done_flag = 0; job_done = 0;
    hold_v = 0; prev_start = 0;
    hv = 0; hq = '0; hp = '0;
    late_cnt = 0;
    for (int i = 0; i < N; i++) begin
      ehd[i] = 0; etl[i] = 0; nfa_cnt[i] = 0;
    end
  endtask

  // One clock: drive at negedge, react to lane valids, check before posedge.
  task automatic tick();
    logic [N-1:0]  exp_v, hs, exp_rr;
    logic          exp_r, exp_mv, exp_last;
    logic [DW-1:0] er;
    phase_t        nph;
    int            lane, ml;
    bit            fin, st;
    @(negedge clk_i);
    ap_start_i = start_lvl;
    nfa_hash_i = hash_lvl;
    if ((phase == P_NFA || phase == P_QRY) && src_q.size() > 0) begin
      if (!hold_v) s_valid_i = ($urandom_range(99) < vprob);
      s_data_i = src_q[0].d;
      s_last_i = src_q[0].l;
    end else begin
      s_valid_i = 1'b0;
      s_data_i  = '0;
      s_last_i  = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (ehd[i] != etl[i] && etm[i][ehd[i] % BD] <= cyc) begin
        res_valid_i[i] = 1'b1;
        res_data_i[i*DW +: DW] = ebuf[i][ehd[i] % BD];
      end else begin
        res_valid_i[i] = 1'b0;
        res_data_i[i*DW +: DW] = DW'($urandom);
      end
    end
    case (mr_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = 1'($urandom_range(1));
      default: m_ready_i = ~m_ready_i;
    endcase
    #1;
    for (int i = 0; i < N; i++) begin
      case (rdy_mode)
        0: eng_ready_i[i] = 1'b1;
        1: eng_ready_i[i] = 1'($urandom_range(1));
        default: begin
          if (i == 2 && eng_valid_o[i] && late_cnt < 3) begin
            eng_ready_i[i] = 1'b0;
            late_cnt++;
          end else begin
            eng_ready_i[i] = 1'b1;
          end
        end
      endcase
    end
    #1;
    nph  = phase;
    fin  = 0;
    st   = 0;
    lane = qin % N;
    ml   = rout % N;
    chk("ap_idle", ap_idle_o, phase == P_IDLE);
    chk("ap_done", ap_done_o, done_flag);
    chk("ap_ready", ap_ready_o, done_flag);

    exp_v = '0;
    exp_r = 1'b0;
    if (phase == P_NFA) begin
      exp_v = s_valid_i ? ~got : '0;
      exp_r = s_valid_i && ((got | eng_ready_i) == {N{1'b1}});
    end else if (phase == P_QRY) begin
      exp_v = s_valid_i ? (one << lane) : '0;
      exp_r = eng_ready_i[lane];
    end
    chk("eng_valid", eng_valid_o, exp_v);
    chk("s_ready", s_ready_o, exp_r);

    exp_mv = 1'b0;
    exp_rr = '0;
    if (phase == P_QRY || phase == P_DRAIN) begin
      exp_mv = res_valid_i[ml];
      if (m_ready_i) exp_rr = one << ml;
    end
    chk("m_valid", m_valid_o, exp_mv);
    chk("res_ready", res_ready_o, exp_rr);
    if (m_valid_o && m_ready_i && exp_mv) begin
      er = ~exp_q[rout];
      chk("m_data", m_data_o, er);
      exp_last = in_done && (rout + 1 == total);
      chk("m_last", m_last_o, exp_last);
      ehd[ml]++;
      rout++;
      if (exp_last) begin
        nph = P_IDLE;
        job_done = 1;
        fin = 1;
      end
    end

    hs = eng_valid_o & eng_ready_i & exp_v;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        chk("eng_data", eng_data_o[i*DW +: DW], src_q[0].d);
        chk("eng_last", eng_last_o[i], src_q[0].l);
        chk("eng_stype", eng_stype_o[i], phase == P_QRY);
        if (phase == P_NFA) begin
          got[i] = 1'b1;
          nfa_cnt[i]++;
        end else begin
          ebuf[i][etl[i] % BD] = ~src_q[0].d;
          etm[i][etl[i] % BD]  = cyc + 1 + lat[i];
          etl[i]++;
        end
        if (i == 2) late_cnt = 0;
      end
    end

    if (s_valid_i && exp_r) begin
      if (phase == P_NFA) begin
        got = '0;
        if (src_q[0].l) begin
          hq = hp;
          hv = 1;
          nph = P_QRY;
        end
      end else begin
        exp_q.push_back(src_q[0].d);
        qin++;
        if (src_q[0].l) begin
          total = qin;
          in_done = 1;
          nph = P_DRAIN;
        end
      end
      void'(src_q.pop_front());
      hold_v = 0;
    end else begin
      hold_v = s_valid_i;
    end

    if (phase == P_IDLE && ap_start_i && !prev_start) begin
      hp  = nfa_hash_i;
      nph = (!hv || nfa_hash_i != hq) ? P_NFA : P_QRY;
      st  = 1;
    end
    prev_start = ap_start_i;

    @(posedge clk_i);
    phase = nph;
    cyc++;
    if (st) done_flag = 0;
    if (fin) begin
      done_flag = 1;
      qin = 0; rout = 0; total = 0;
      in_done = 0;
      exp_q.delete();
    end
  endtask

  task automatic begin_job(input logic [HW-1:0] h, input int nn, input int nq);
    bit    rl;
    beat_t b;
    rl = !hv || h != hq;
    src_q.delete();
    got = '0;
    job_done = 0;
    hold_v = 0;
    late_cnt = 0;
    for (int i = 0; i < N; i++) nfa_cnt[i] = 0;
    n_nfa_exp = rl ? nn : 0;
    if (rl) begin
      for (int k = 0; k < nn; k++) begin
        b.d = DW'($urandom);
        b.l = (k == nn - 1);
        src_q.push_back(b);
      end
    end
    for (int k = 0; k < nq; k++) begin
      b.d = DW'($urandom);
      b.l = (k == nq - 1);
      src_q.push_back(b);
    end
    hash_lvl = h;
    if (start_lvl) begin
      start_lvl = 0;
      tick();
    end
    start_lvl = 1;
  endtask

  task automatic finish_job();
    for (int c = 0; c < 3000 && !job_done; c++) tick();
    chk("job_finished", job_done, 1);
    for (int i = 0; i < N; i++) chk("nfa_beats_lane", nfa_cnt[i], n_nfa_exp);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i       = 1'b1;
    start_lvl   = 1'b0;
    ap_start_i  = 1'b0;
    s_valid_i   = 1'b0;
    s_data_i    = '0;
    s_last_i    = 1'b0;
    eng_ready_i = '0;
    res_valid_i = '0;
    res_data_i  = '0;
    m_ready_i   = 1'b0;
    #1;
    chk("rst_ap_idle", ap_idle_o, 1);
    chk("rst_ap_done", ap_done_o, 0);
    chk("rst_ap_ready", ap_ready_o, 0);
    chk("rst_s_ready", s_ready_o, 0);
    chk("rst_eng_valid", eng_valid_o, 0);
    chk("rst_eng_last", eng_last_o, 0);
    chk("rst_eng_stype", eng_stype_o, 0);
    chk("rst_eng_data", eng_data_o[63:0], 0);
    chk("rst_res_ready", res_ready_o, 0);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_last", m_last_o, 0);
    chk("rst_m_data", m_data_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  logic [HW-1:0] h;

  initial begin
    rst_i       = 1'b1;
    ap_start_i  = 1'b0;
    nfa_hash_i  = '0;
    s_valid_i   = 1'b0;
    s_data_i    = '0;
    s_last_i    = 1'b0;
    eng_ready_i = '0;
    res_valid_i = '0;
    res_data_i  = '0;
    m_ready_i   = 1'b0;
    start_lvl   = 0;
    hash_lvl    = '0;
    rdy_mode    = 0;
    mr_mode     = 0;
    vprob       = 100;
    cyc         = 0;
    for (int i = 0; i < N; i++) lat[i] = 0;
    model_reset();
    do_reset();

    begin_job(64'hA5, 3, 8);
    finish_job();
    repeat (4) tick();

    begin_job(64'hA5, 3, 8);
    finish_job();

    rdy_mode = 2;
    begin_job(64'h1234, 4, 6);
    finish_job();
    rdy_mode = 0;

    lat[1]  = 10;
    mr_mode = 2;
    begin_job(64'h1234, 2, 5);
    finish_job();
    lat[1]  = 0;
    mr_mode = 0;

    begin_job(64'h1234, 2, 12);
    repeat (4) tick();
    start_lvl = 0;
    tick();
    start_lvl = 1;
    finish_job();
    repeat (3) tick();

    begin_job(64'h1234, 2, 10);
    for (int c = 0; c < 50 && !(phase == P_QRY && qin >= 2); c++) tick();
    chk("reached_query", (phase == P_QRY && qin >= 2), 1);
    do_reset();
    begin_job(64'h1234, 2, 4);
    finish_job();

    for (int j = 0; j < 10; j++) begin
      rdy_mode = $urandom_range(1);
      mr_mode  = $urandom_range(2);
      vprob    = $urandom_range(100, 30);
      for (int i = 0; i < N; i++) lat[i] = $urandom_range(6);
      if ($urandom_range(2) == 0) h = hq;
      else h = {$urandom, $urandom};
      begin_job(h, $urandom_range(5, 1), $urandom_range(20, 1));
      finish_job();
      repeat (2) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
